// File: rtl/la_rrpick4.sv
// Combinational rotating-priority picker for four requesters.
// Returns the first asserted request scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
module la_rrpick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       any,
  output logic [1:0] idx
);

  logic [3:0] rot;
  logic [1:0] off;

  // Rotate so bit 0 is the highest-priority requester, then find the lowest set bit.
  always_comb begin
    rot = 4'({req, req} >> ptr);
    off = 2'd0;
    if      (rot[0]) off = 2'd0;
    else if (rot[1]) off = 2'd1;
    else if (rot[2]) off = 2'd2;
    else if (rot[3]) off = 2'd3;
    any = |rot;
    idx = ptr + off;
  end

endmodule

// File: rtl/la_mux4arb.sv
// Round-robin arbiter driving the selects of a shared 4:1 mux.
// Owner keeps the grant while requesting; an optional hold limit forces a
// handoff when others are waiting. Handoffs are zero-bubble when possible.
module la_mux4arb #(
  parameter string PROP    = "DEFAULT",
  parameter int    MAXHOLD = 16
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       en,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic       valid,
  output logic       s0,
  output logic       s1
);

  localparam int            HW    = (MAXHOLD < 1) ? 1 : $clog2(MAXHOLD + 1);
  localparam logic [HW-1:0] HMAX  = HW'(MAXHOLD);
  localparam logic [HW-1:0] HONE  = HW'(1);
  localparam bit            LIMIT = (MAXHOLD != 0);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  logic          state, state_n;
  logic [1:0]    ptr, ptr_n;
  logic [1:0]    sel, sel_n;
  logic [3:0]    grant_q, grant_n;
  logic          valid_q, valid_n;
  logic [HW-1:0] holdcnt, hold_n;

  logic [3:0]    own_oh, others;
  logic          idle_any, hand_any;
  logic [1:0]    idle_idx, hand_idx;
  logic          rel_vol, rel_frc;

  // Fresh pick from idle uses the live pointer.
  la_rrpick4 u_pick_idle (
    .req (req),
    .ptr (ptr),
    .any (idle_any),
    .idx (idle_idx)
  );

  // Handoff pick: owner masked, priority starts just past the owner
  // (that is the pointer value being written on the release edge).
  la_rrpick4 u_pick_hand (
    .req (others),
    .ptr (sel + 2'd1),
    .any (hand_any),
    .idx (hand_idx)
  );

  // Release conditions for the current owner.
  always_comb begin
    own_oh  = 4'b0001 << sel;
    others  = req & ~own_oh;
    rel_vol = ~req[sel];
    rel_frc = LIMIT && (holdcnt == HMAX) && (|others);
  end

  // State and datapath registers; reset clears outputs asynchronously.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state   <= ST_IDLE;
      ptr     <= 2'd0;
      sel     <= 2'd0;
      grant_q <= 4'b0000;
      valid_q <= 1'b0;
      holdcnt <= '0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      sel     <= sel_n;
      grant_q <= grant_n;
      valid_q <= valid_n;
      holdcnt <= hold_n;
    end
  end

  // Next-state: grant from idle, hold / count, or release with optional handoff.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    sel_n   = sel;
    grant_n = grant_q;
    valid_n = valid_q;
    hold_n  = holdcnt;
    case (state)
      ST_IDLE: begin
        if (en && idle_any) begin
          state_n = ST_GRANT;
          sel_n   = idle_idx;
          grant_n = 4'b0001 << idle_idx;
          valid_n = 1'b1;
          hold_n  = HONE;
        end
      end
      default: begin
        if (rel_vol || rel_frc) begin
          ptr_n = sel + 2'd1;
          if (en && hand_any) begin
            sel_n   = hand_idx;
            grant_n = 4'b0001 << hand_idx;
            hold_n  = HONE;
          end else begin
            state_n = ST_IDLE;
            grant_n = 4'b0000;
            valid_n = 1'b0;
          end
        end else if (LIMIT && (holdcnt != HMAX)) begin
          hold_n = holdcnt + HONE;
        end
      end
    endcase
  end

  // Outputs come straight from registers; selects keep the last owner when idle.
  always_comb begin
    grant = grant_q;
    valid = valid_q;
    s0    = sel[0];
    s1    = sel[1];
  end

endmodule

// File: tb/tb_la_mux4arb.sv
// Bench for la_mux4arb: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a behavioural owner model.
module tb_la_mux4arb;

  localparam int MAXH = 4;

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic       en = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] grant;
  logic       valid, s0, s1;

  int checks = 0;
  int errors = 0;

  la_mux4arb #(.PROP("DEFAULT"), .MAXHOLD(MAXH)) dut (
    .clk    (clk),
    .nreset (nreset),
    .en     (en),
    .req    (req),
    .grant  (grant),
    .valid  (valid),
    .s0     (s0),
    .s1     (s1)
  );

  always #5 clk = ~clk;

  // Behavioural model: who owns the mux (-1 = nobody), how long, where priority starts.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_hold  = 0;
  int m_sel   = 0;

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge nreset) begin
    int o, n, hold, ptr, sel;
    logic [3:0] oth;
    if (!nreset) begin
      m_owner <= -1;
      m_ptr   <= 0;
      m_hold  <= 0;
      m_sel   <= 0;
    end else begin
      o = m_owner; hold = m_hold; ptr = m_ptr; sel = m_sel;
      if (o < 0) begin
        if (en && req != 4'b0) begin
          o = pick(req, ptr); sel = o; hold = 1;
        end
      end else begin
        oth = req & ~(4'b0001 << o);
        if (!req[o] || (MAXH != 0 && hold >= MAXH && oth != 4'b0)) begin
          ptr = (o + 1) % 4;
          if (en && oth != 4'b0) begin
            n = pick(oth, ptr); o = n; sel = n; hold = 1;
          end else begin
            o = -1;
          end
        end else if (MAXH != 0 && hold < MAXH) begin
          hold = hold + 1;
        end
      end
      m_owner <= o; m_hold <= hold; m_ptr <= ptr; m_sel <= sel;
    end
  end

  // Every cycle, away from the active edge: outputs must match the model.
  always @(negedge clk) begin
    chk("model_grant", {28'b0, grant}, (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
    chk("model_valid", {31'b0, valid}, (m_owner >= 0) ? 32'd1 : 32'd0);
    chk("model_sel",   {30'b0, s1, s0}, 32'(m_sel));
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    req    = 4'b0000;
    step(2);
    nreset = 1'b1;
  endtask

  initial begin
    // Reset state and the simplest grant/release.
    en = 1'b1;
    do_reset();
    chk("rst_grant", {28'b0, grant}, 32'h0);
    chk("rst_valid", {31'b0, valid}, 32'h0);
    chk("rst_sel",   {30'b0, s1, s0}, 32'h0);
    req = 4'b0001; step();
    chk("single_grant", {28'b0, grant}, 32'h1);
    chk("single_valid", {31'b0, valid}, 32'h1);
    req = 4'b0000; step();
    chk("drop_grant", {28'b0, grant}, 32'h0);
    chk("drop_valid", {31'b0, valid}, 32'h0);
    chk("drop_sel",   {30'b0, s1, s0}, 32'h0);

    // All requesting: each owner for exactly MAXH cycles, no gaps.
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 20; k++) begin
      step();
      chk("rr_seq", {28'b0, grant}, 32'd1 << ((k / 4) % 4));
    end

    // Lone requester is never forced off.
    do_reset();
    req = 4'b0100;
    for (int k = 0; k < 20; k++) begin
      step();
      if (k % 5 == 4) begin
        chk("lone_grant", {28'b0, grant}, 32'h4);
        chk("lone_sel",   {30'b0, s1, s0}, 32'h2);
      end
    end

    // Zero-bubble handoff and immunity to non-owner request changes.
    do_reset();
    req = 4'b0010; step();
    chk("own1", {28'b0, grant}, 32'h2);
    req = 4'b0110; step();
    chk("own1_hold", {28'b0, grant}, 32'h2);
    req = 4'b0100; step();
    chk("handoff_2", {28'b0, grant}, 32'h4);
    req = 4'b0101; step();
    chk("nonowner_chg", {28'b0, grant}, 32'h4);

    // en=0 keeps the current owner; grants resume only after en returns.
    do_reset();
    req = 4'b1000; step();
    chk("own3", {28'b0, grant}, 32'h8);
    en = 1'b0; req = 4'b1001; step();
    chk("en0_hold", {28'b0, grant}, 32'h8);
    req = 4'b0001; step();
    chk("en0_release", {28'b0, grant}, 32'h0);
    step();
    chk("en0_idle", {28'b0, grant}, 32'h0);
    en = 1'b1; step();
    chk("en1_grant", {28'b0, grant}, 32'h1);

    // Async reset mid-grant clears outputs at once and restores ptr=0.
    do_reset();
    req = 4'b0100; step();
    chk("pre_rst", {28'b0, grant}, 32'h4);
    #2 nreset = 1'b0;
    #1;
    chk("async_grant", {28'b0, grant}, 32'h0);
    chk("async_valid", {31'b0, valid}, 32'h0);
    chk("async_sel",   {30'b0, s1, s0}, 32'h0);
    req = 4'b1111;
    step();
    nreset = 1'b1;
    step();
    chk("post_rst", {28'b0, grant}, 32'h1);

    // Randomized traffic against the model, with occasional resets.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 2) == 0) req = 4'($urandom);
      en = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 299) == 0) nreset = 1'b0;
      else nreset = 1'b1;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
